// File: rtl/ascon_cfg.sv
// ascon_cfg: shared constants and state encoding for the Ascon block padder
package ascon_cfg;
  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h80;
  localparam int RATE64_BYTES = 8;
  localparam int RATE128_BYTES = 16;
  typedef enum logic [1:0] {FILL, OUT, TAIL} pad_state_e;
endpackage

// File: rtl/ascon_pad_merge.sv
// ascon_pad_merge: merges one input word into the accumulator and places the pad byte
module ascon_pad_merge
  import ascon_cfg::*;
#(
  parameter logic [7:0] PAD_BYTE = DEFAULT_PAD_BYTE
) (
  input  logic [63:0] acc,
  input  logic [31:0] data,
  input  logic [3:0]  cnt,
  input  logic [2:0]  b,
  input  logic        last,
  output logic [63:0] merged,
  output logic [3:0]  c,
  output logic        pad_placed
);
  logic [2:0]  bb;
  logic [31:0] keep;
  assign bb = (!last || b > 3'd4) ? 3'd4 : b;
  assign c = cnt + {1'b0, bb};
  // unused trailing bytes are masked so the accumulator tail stays zero
  assign keep = ~(32'hffff_ffff >> {bb, 3'b0});
  assign pad_placed = last && c < 4'(RATE64_BYTES);
  assign merged = acc | ({data & keep, 32'h0} >> {cnt, 3'b0})
                | (pad_placed ? {PAD_BYTE, 56'h0} >> {c, 3'b0} : 64'h0);
endmodule

// File: rtl/ascon_block_padder.sv
// ascon_block_padder: packs a 32-bit byte stream into 10*-padded 64-bit Ascon rate blocks
module ascon_block_padder
  import ascon_cfg::*;
#(
  parameter logic [7:0] PAD_BYTE = DEFAULT_PAD_BYTE
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        rate128_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  bytes_i,
  input  logic        last_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [63:0] block_o,
  output logic        block_valid_o,
  output logic        block_last_o,
  input  logic        block_ready_i
);
  pad_state_e  state, state_d;
  logic [63:0] acc, merged;
  logic [3:0]  cnt, c;
  logic        half, pad_done, r128, eom, busy, pad_placed, take, give, done;

  ascon_pad_merge #(.PAD_BYTE(PAD_BYTE)) u_merge (
    .acc        (acc),
    .data       (data_i),
    .cnt        (cnt),
    .b          (bytes_i),
    .last       (last_i),
    .merged     (merged),
    .c          (c),
    .pad_placed (pad_placed)
  );

  assign take = state == FILL && valid_i;
  assign give = state == OUT && block_ready_i;
  // eom marks that the last word arrived; tail blocks follow until pad and rate are complete
  assign done = eom && pad_done && (!r128 || half);
  assign ready_o = state == FILL;
  assign block_valid_o = state == OUT;
  assign block_last_o = block_valid_o && done;
  assign block_o = block_valid_o ? acc : 64'h0;

  always_comb begin
    state_d = state == TAIL ? OUT
            : give ? ((eom && !done) ? TAIL : FILL)
            : (take && (last_i || c == 4'(RATE64_BYTES))) ? OUT
            : state;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= FILL;
    else state <= clear_i ? FILL : state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc      <= 64'h0;
      cnt      <= 4'h0;
      half     <= 1'b0;
      pad_done <= 1'b0;
      r128     <= 1'b0;
      eom      <= 1'b0;
      busy     <= 1'b0;
    end else if (clear_i) begin
      acc      <= 64'h0;
      cnt      <= 4'h0;
      half     <= 1'b0;
      pad_done <= 1'b0;
      r128     <= 1'b0;
      eom      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (take) begin
        acc      <= merged;
        cnt      <= c;
        busy     <= 1'b1;
        eom      <= last_i;
        pad_done <= pad_placed;
        if (!busy) r128 <= rate128_i;
      end
      if (give) begin
        acc  <= 64'h0;
        cnt  <= 4'h0;
        half <= r128 && !half;
        if (done) begin
          half     <= 1'b0;
          pad_done <= 1'b0;
          eom      <= 1'b0;
          busy     <= 1'b0;
        end
      end
      if (state == TAIL) begin
        acc      <= pad_done ? 64'h0 : {PAD_BYTE, 56'h0};
        pad_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ascon_block_padder.sv
// tb_ascon_block_padder: randomized messages checked against a byte-level 10* padding model
module tb_ascon_block_padder;
  logic        clk = 1'b0;
  logic        rst_n_i, clear_i, rate128_i, last_i, valid_i, block_ready_i;
  logic        ready_o, block_valid_o, block_last_o;
  logic [31:0] data_i;
  logic [2:0]  bytes_i;
  logic [63:0] block_o;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ascon_block_padder dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .clear_i       (clear_i),
    .rate128_i     (rate128_i),
    .data_i        (data_i),
    .bytes_i       (bytes_i),
    .last_i        (last_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_last_o  (block_last_o),
    .block_ready_i (block_ready_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, 64'(ready_o), 64'd1);
    check_eq({tag, "_valid"}, 64'(block_valid_o), 64'd0);
    check_eq({tag, "_last"}, 64'(block_last_o), 64'd0);
    check_eq({tag, "_block"}, block_o, 64'd0);
  endtask

  task automatic run_msg(input byte unsigned msg[$], input bit r128, input int stall);
    byte unsigned p[$];
    logic [63:0]  exp_d[$];
    bit           exp_l[$];
    logic [63:0]  d;
    int len = msg.size();
    int nw = len == 0 ? 1 : (len + 3) / 4;
    int wi = 0;
    int cyc = 0;
    int rem;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % (r128 ? 16 : 8) != 0) p.push_back(8'h00);
    for (int i = 0; i < p.size(); i += 8) begin
      d = 64'h0;
      for (int k = 0; k < 8; k++) d = {d[55:0], p[i+k]};
      exp_d.push_back(d);
      exp_l.push_back(i + 8 == p.size());
    end
    rate128_i = r128;
    while (exp_d.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (wi > 0) rate128_i = 1'($urandom_range(1));
      check_eq("no_bypass", 64'(ready_o & block_valid_o), 64'd0);
      check_eq("last_needs_valid", 64'(block_last_o & ~block_valid_o), 64'd0);
      block_ready_i = $urandom_range(99) >= stall;
      if (block_valid_o && block_ready_i) begin
        check_eq("block", block_o, exp_d.pop_front());
        check_eq("block_last", 64'(block_last_o), 64'(exp_l.pop_front()));
      end
      valid_i = 1'b0;
      if (wi < nw && $urandom_range(99) >= stall) begin
        for (int k = 0; k < 4; k++)
          data_i[31-8*k -: 8] = (4*wi + k < len) ? msg[4*wi+k] : 8'($urandom);
        last_i = wi == nw - 1;
        rem = len - 4*wi;
        bytes_i = !last_i ? 3'($urandom)
                : (rem == 4 && $urandom_range(1) == 1) ? 3'($urandom_range(7, 5))
                : 3'(rem);
        valid_i = 1'b1;
        if (ready_o) wi++;
      end
    end
    if (exp_d.size() > 0) check_eq("timeout", 64'(exp_d.size()), 64'd0);
    @(negedge clk);
    valid_i = 1'b0;
    block_ready_i = 1'b0;
    check_eq("idle_ready", 64'(ready_o), 64'd1);
  endtask

  initial begin
    byte unsigned m[$];
    rst_n_i = 1'b0; clear_i = 1'b0; rate128_i = 1'b0; last_i = 1'b0;
    valid_i = 1'b0; block_ready_i = 1'b0; data_i = '0; bytes_i = '0;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n_i = 1'b1;
    @(negedge clk);
    check_idle("reset");

    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b};
    run_msg(m, 1'b0, 0);
    m = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    run_msg(m, 1'b0, 0);
    m = '{8'haa, 8'hbb};
    run_msg(m, 1'b1, 0);
    m.delete();
    run_msg(m, 1'b0, 0);
    run_msg(m, 1'b1, 0);

    // back-pressure: consumer stalls while the upstream keeps presenting junk
    @(negedge clk);
    rate128_i = 1'b0; data_i = 32'h11223344; bytes_i = 3'd4; last_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    data_i = 32'hdeadbeef; bytes_i = 3'd3;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_block", block_o, 64'h1122334480000000);
      check_eq("stall_valid", 64'(block_valid_o), 64'd1);
      check_eq("stall_last", 64'(block_last_o), 64'd1);
      check_eq("stall_ready", 64'(ready_o), 64'd0);
      @(negedge clk);
    end
    block_ready_i = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    block_ready_i = 1'b0;
    check_idle("release");

    // clear with a half-filled accumulator
    data_i = 32'h01020304; last_i = 1'b0; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check_idle("clear_fill");

    // clear wins over a handshake in OUT
    data_i = 32'ha1a2a3a4; valid_i = 1'b1;
    @(negedge clk);
    data_i = 32'hb1b2b3b4;
    @(negedge clk);
    valid_i = 1'b0;
    check_eq("pre_clear_valid", 64'(block_valid_o), 64'd1);
    clear_i = 1'b1; block_ready_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; block_ready_i = 1'b0;
    check_idle("clear_out");
    m = '{8'hc1, 8'hc2, 8'hc3};
    run_msg(m, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      m.delete();
      for (int i = 0; i < $urandom_range(40); i++) m.push_back(8'($urandom));
      run_msg(m, 1'($urandom_range(1)), $urandom_range(60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
